// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared sizes and state type for the 16-way round-robin arbiter
package arb_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/onehot_encoder_16to4.sv
// rtl/onehot_encoder_16to4.sv - one-hot to binary index, zero for any non-one-hot input
module onehot_encoder_16to4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] idx_or;
  logic             is_onehot;

  always_comb begin
    idx_or = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx_or = idx_or | IDX_W'(i);
    end
    is_onehot = (onehot != '0) && ((onehot & (onehot - N_REQ'(1))) == '0);
    idx       = is_onehot ? idx_or : '0;
  end

endmodule

// File: rtl/round_robin_arbiter_16.sv
// rtl/round_robin_arbiter_16.sv - 16-requester round-robin arbiter with registered one-hot grant and hold limit
module round_robin_arbiter_16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] hold_cnt, cnt_d;
  logic [N_REQ-1:0] gnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             busy_d, tmo_d;

  logic [N_REQ-1:0] req_rot, first_rot, sel;
  logic [IDX_W-1:0] sel_idx;
  logic             release_now;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_rot = '0;
    sel     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rot[i] = req[IDX_W'(i) + ptr];
    end
    first_rot = req_rot & (~req_rot + N_REQ'(1));
    for (int i = 0; i < N_REQ; i++) begin
      sel[IDX_W'(i) + ptr] = first_rot[i];
    end
  end

  onehot_encoder_16to4 u_enc (
    .onehot (sel),
    .idx    (sel_idx)
  );

  always_comb begin
    state_d     = state;
    gnt_d       = gnt;
    idx_d       = gnt_idx;
    busy_d      = busy;
    tmo_d       = 1'b0;
    ptr_d       = ptr;
    cnt_d       = hold_cnt;
    release_now = 1'b0;

    case (state)
      IDLE: begin
        if (en && (req != '0)) begin
          gnt_d   = sel;
          idx_d   = sel_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Owner-driven release outranks the hold limit on the same cycle.
        if (!en || done || !req[gnt_idx]) begin
          release_now = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
          release_now = 1'b1;
          tmo_d       = 1'b1;
        end else begin
          cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_now) begin
      gnt_d   = '0;
      busy_d  = 1'b0;
      state_d = IDLE;
      ptr_d   = gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      gnt_idx  <= idx_d;
      busy     <= busy_d;
      timeout  <= tmo_d;
      ptr      <= ptr_d;
      hold_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_16.sv
// tb/tb_round_robin_arbiter_16.sv - scoreboard bench for round_robin_arbiter_16
module tb_round_robin_arbiter_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_grant;
    logic [15:0] gnt;
    logic [3:0]  idx;
    bit          tmo;
    int          len;
  } exp_t;

  exp_t exp_q[$];

  round_robin_arbiter_16 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_grant(input logic [15:0] g, input logic [3:0] i);
    exp_t e;
    e.is_grant = 1'b1; e.gnt = g; e.idx = i; e.tmo = 1'b0; e.len = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_release(input logic [3:0] i, input bit t, input int n);
    exp_t e;
    e.is_grant = 1'b0; e.gnt = '0; e.idx = i; e.tmo = t; e.len = n;
    exp_q.push_back(e);
  endtask

  // Grant, hold for n busy cycles, release via done, then drop req for one idle cycle.
  task automatic do_grant(input logic [15:0] r, input logic [15:0] g, input logic [3:0] i, input int n);
    push_grant(g, i);
    push_release(i, 1'b0, n);
    req = r;
    tick(1);
    tick(n - 1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    req  = '0;
    tick(1);
  endtask

  // Monitor: pops one expectation per grant (busy rise) and per release (busy fall).
  initial begin
    logic prev_busy;
    int   len;
    exp_t e;
    prev_busy = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        len = 0;
      end else begin
        if (busy && !prev_busy) begin
          len = 1;
          if (exp_q.size() == 0 || !exp_q[0].is_grant) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: got gnt=%0h idx=%0d at %0t", gnt, gnt_idx, $time);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            e = exp_q.pop_front();
            chk("grant_onehot", 32'(gnt), 32'(e.gnt));
            chk("grant_idx", 32'(gnt_idx), 32'(e.idx));
          end
        end else if (busy && prev_busy) begin
          len++;
        end else if (!busy && prev_busy) begin
          if (exp_q.size() == 0 || exp_q[0].is_grant) begin
            checks++; errors++;
            $display("FAIL unexpected_release: got idx=%0d at %0t", gnt_idx, $time);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            e = exp_q.pop_front();
            chk("release_gnt_zero", 32'(gnt), 32'h0);
            chk("release_idx_kept", 32'(gnt_idx), 32'(e.idx));
            chk("release_timeout", 32'(timeout), 32'(e.tmo));
            chk("busy_cycles", 32'(len), 32'(e.len));
          end
        end
        if (timeout && !(prev_busy && !busy)) begin
          checks++; errors++;
          $display("FAIL stray_timeout: got 1 expected 0 at %0t", $time);
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; done = 1'b0;
    tick(2);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_idx", 32'(gnt_idx), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;
    tick(1);
    en = 1'b1;

    do_grant(16'h0011, 16'h0001, 4'd0, 1);
    do_grant(16'h0011, 16'h0010, 4'd4, 2);

    do_grant(16'h8001, 16'h8000, 4'd15, 1);
    do_grant(16'h8001, 16'h0001, 4'd0, 1);
    do_grant(16'h8001, 16'h8000, 4'd15, 1);

    // Hold limit: ptr=0, only bit 2 requesting, never releases on its own.
    push_grant(16'h0004, 4'd2);
    push_release(4'd2, 1'b1, 4);
    req = 16'h0004;
    tick(5);
    req = '0;
    tick(1);
    do_grant(16'h0009, 16'h0008, 4'd3, 1);

    // done on the last allowed busy cycle wins over the timeout.
    do_grant(16'h0020, 16'h0020, 4'd5, 4);

    push_grant(16'h0040, 4'd6);
    push_release(4'd6, 1'b0, 2);
    req = 16'h0040;
    tick(2);
    en = 1'b0;
    tick(4);
    push_grant(16'h0040, 4'd6);
    push_release(4'd6, 1'b0, 2);
    en = 1'b1;
    tick(2);
    req = '0;
    tick(2);

    push_grant(16'h0100, 4'd8);
    req = 16'h0100;
    tick(2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_idx", 32'(gnt_idx), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_timeout", 32'(timeout), 32'h0);
    req = 16'h0300;
    @(posedge clk);
    #1 rst = 1'b0;
    push_grant(16'h0100, 4'd8);
    push_release(4'd8, 1'b0, 1);
    tick(1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    req = '0;
    tick(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_16.md
# round_robin_arbiter_16

Round-robin arbiter that shares one downstream resource among 16 requesters. It produces a registered one-hot grant and its 4-bit binary index, and holds each grant until the owner releases it or a hold-time limit expires. It sits in front of the 16-input encoder datapath and drives that datapath's enable and one-hot select, so the encoder only ever sees a legal one-hot input while enabled.

## Interface
- MAX_HOLD, 16: maximum busy cycles per grant, legal range 0..255; 0 disables the timeout.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbiter enable; 0 blocks new grants and forces release of any current grant.
- req  in  16  request vector; bit i is requester i.
- done  in  1  owner release strobe; sampled only while busy.
- gnt  out  16  registered one-hot grant; all zeros when idle.
- gnt_idx  out  4  binary index of the current or last grant.
- busy  out  1  a grant is active (equal to |gnt).
- timeout  out  1  one-cycle pulse marking a forced release by hold limit.

## Operation
- States: IDLE and BUSY.
- Internal state: ptr[3:0] (search start point), hold_cnt[7:0].
- IDLE, en=1, |req=1:
  - Select the first set req bit scanning ptr, ptr+1, … modulo 16.
  - Load gnt with that bit, load gnt_idx with its index, set busy=1, clear hold_cnt, go to BUSY.
- IDLE, en=0 or req=0: stay in IDLE, outputs unchanged.
- BUSY checks, in this priority order:
  1. en=0, done=1, or req[gnt_idx]=0 → normal release.
  2. MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 → forced release, timeout=1 for exactly one cycle.
  3. Otherwise hold_cnt+=1 and stay in BUSY.
- Any release:
  - gnt=0, busy=0, go to IDLE.
  - ptr=gnt_idx+1, wrapping 15→0.
  - gnt_idx keeps its value.
- No grant is issued in the release cycle, so grants are separated by at least one idle cycle.
- timeout is 0 on every cycle except the single forced-release cycle.
- Reset (async, any time, including mid-grant): state=IDLE, gnt=0, gnt_idx=0, busy=0, timeout=0, ptr=0, hold_cnt=0.

## Timing
- Grant latency is 1 cycle: req sampled at edge k, gnt/busy visible after edge k.
- Release latency is 1 cycle: done sampled at edge k, gnt=0 after edge k.
- Next possible grant is after edge k+1.
- With a continuously held request and no done, busy stays high for exactly MAX_HOLD cycles.
- All outputs are registered; there is no combinational path from input to output.
- req changes on bits other than gnt_idx have no effect while BUSY.

## Structure
- Package arb_pkg holds:
  - N_REQ=16, IDX_W=4, CNT_W=8.
  - State enum arb_state_t {IDLE, BUSY}.
- Sub-module onehot_encoder_16to4: combinational one-hot → index, outputs 0 for non-one-hot input.
  - Used to derive the next gnt_idx from the selected one-hot vector.
- Rotating priority select (rotate req by ptr, find first set bit, rotate back) stays in the top module.

## Test plan
- Basic grant and rotation: reset, en=1, req=16'h0011, ptr=0 → after 1 cycle gnt=16'h0001, gnt_idx=0, busy=1. Pulse done → gnt=0 next cycle. Next grant gnt=16'h0010, gnt_idx=4.
- Wrap-around: grant index 15 with req=16'h8001, then done → ptr=0 and next grant is gnt_idx=0. Then grant 0 and done with req=16'h8001 → next grant gnt_idx=15.
- Timeout: MAX_HOLD=4, req=16'h0004 held, done=0 → busy high exactly 4 cycles, timeout=1 on the release cycle, ptr=3.
- Release precedence: MAX_HOLD=4, done=1 on the 4th busy cycle → normal release, timeout stays 0.
- Enable drop and request drop: en→0 mid-grant → gnt=0 next cycle and no regrant while en=0. Separately, clearing req[gnt_idx] → release next cycle.
- Async reset mid-grant: assert rst while gnt=16'h0100 → gnt=0, gnt_idx=0, busy=0 immediately without waiting for a clock edge. After deassert with req=16'h0300 → grant gnt_idx=8, since ptr is back to 0.
